rv32_mod_bus_arbiter: RTL and testbench

RV32_MOD_BUS_ARBITER -- requirements
Module: rv32_mod_bus_arbiter

---
 rtl/rv32_mod_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_rv32_mod_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_bus_arbiter.sv
// Two-requester (fetch / load-store) round-robin arbiter onto a single memory port.
// Optional stall watchdog enabled by defining RV32_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module rv32_mod_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_data_o,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_i,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_data_o,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e      state_q;
  logic        last_grant_q;  // 1'b1 = data was granted last
  logic        mem_req_q;
  logic        mem_wr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        timeout_s;
  logic        done_s;
  logic        grant_i_s;

`ifdef RV32_ARB_TIMEOUT_EN
  logic [31:0] cnt_q;

  assign timeout_s = (state_q != IDLE) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Stall counter: cleared on grant/idle, counts BUSY cycles with no memory response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 32'd0;
    end else if (state_q == IDLE || done_s) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
`else
  logic [31:0] timeout_unused_s;

  assign timeout_unused_s = 32'(TIMEOUT_CYCLES);
  assign timeout_s        = 1'b0;
`endif

  assign done_s    = mem_ack | mem_err | timeout_s;
  assign grant_i_s = instr_req & (~data_req | last_grant_q);

  // Arbitration FSM with registered memory-port fields.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_be_q     <= 4'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i_s) begin
            state_q      <= BUSY_I;
            last_grant_q <= 1'b0;
            mem_req_q    <= 1'b1;
            mem_wr_q     <= 1'b0;
            mem_be_q     <= 4'hF;
            mem_addr_q   <= instr_addr;
            mem_wdata_q  <= 32'h0;
          end else if (data_req) begin
            state_q      <= BUSY_D;
            last_grant_q <= 1'b1;
            mem_req_q    <= 1'b1;
            mem_wr_q     <= data_wr;
            mem_be_q     <= data_be;
            mem_addr_q   <= data_addr;
            mem_wdata_q  <= data_data_i;
          end else begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done_s) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end else begin
            state_q   <= state_q;
            mem_req_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data_o = mem_wdata_q;

  // Responses reach a requester only while it is granted and still requesting.
  assign instr_ack    = (state_q == BUSY_I) & mem_ack & instr_req;
  assign instr_err    = (state_q == BUSY_I) & instr_req & (mem_err | (timeout_s & ~mem_ack));
  assign data_ack     = (state_q == BUSY_D) & mem_ack & data_req;
  assign data_err     = (state_q == BUSY_D) & data_req & (mem_err | (timeout_s & ~mem_ack));
  assign instr_data_o = mem_data_i;
  assign data_data_o  = mem_data_i;

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// Directed self-checking bench for rv32_mod_bus_arbiter (timeout path follows RV32_ARB_TIMEOUT_EN).
module tb_rv32_mod_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic        instr_err;
  logic [31:0] instr_data_o;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_data_i;
  logic        data_ack;
  logic        data_err;
  logic [31:0] data_data_o;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_o;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_data_i;

  int checks = 0;
  int errors = 0;

  rv32_mod_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
    .instr_err(instr_err), .instr_data_o(instr_data_o),
    .data_req(data_req), .data_wr(data_wr), .data_be(data_be), .data_addr(data_addr),
    .data_data_i(data_data_i), .data_ack(data_ack), .data_err(data_err),
    .data_data_o(data_data_o),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_data_o(mem_data_o), .mem_ack(mem_ack), .mem_err(mem_err), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_data_i = 32'h0;
    mem_ack = 1'b0; mem_err = 1'b0; mem_data_i = 32'h0;
    tick(); tick();
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    chk("rst_acks", {28'd0, instr_ack, instr_err, data_ack, data_err}, 32'd0);
    reset = 1'b1;

    // Single fetch with same-cycle ack.
    instr_req = 1'b1; instr_addr = 32'h0000_0100;
    tick();
    mem_ack = 1'b1; mem_data_i = 32'h0000_0013;
    #1;
    chk("f_mem_req", {31'd0, mem_req}, 32'd1);
    chk("f_mem_be", {28'd0, mem_be}, 32'hF);
    chk("f_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("f_mem_addr", mem_addr, 32'h0000_0100);
    chk("f_instr_ack", {31'd0, instr_ack}, 32'd1);
    chk("f_instr_data", instr_data_o, 32'h0000_0013);
    chk("f_data_ack", {31'd0, data_ack}, 32'd0);
    tick();
    instr_req = 1'b0; mem_ack = 1'b0;
    #1;
    chk("f_idle_req", {31'd0, mem_req}, 32'd0);
    chk("f_idle_ack", {31'd0, instr_ack}, 32'd0);

    // Store held for 3 stalled cycles, then acked.
    data_req = 1'b1; data_wr = 1'b1; data_be = 4'b0011;
    data_addr = 32'h1000_0004; data_data_i = 32'hDEAD_BEEF;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("s_mem_req", {31'd0, mem_req}, 32'd1);
      chk("s_mem_wr", {31'd0, mem_wr}, 32'd1);
      chk("s_mem_be", {28'd0, mem_be}, 32'h3);
      chk("s_mem_addr", mem_addr, 32'h1000_0004);
      chk("s_mem_data", mem_data_o, 32'hDEAD_BEEF);
      chk("s_stall_ack", {31'd0, data_ack}, 32'd0);
      tick();
    end
    mem_ack = 1'b1; mem_data_i = 32'hCAFE_0001;
    #1;
    chk("s_data_ack", {31'd0, data_ack}, 32'd1);
    chk("s_data_rd", data_data_o, 32'hCAFE_0001);
    chk("s_instr_ack", {31'd0, instr_ack}, 32'd0);
    tick();
    data_req = 1'b0; data_wr = 1'b0; mem_ack = 1'b0;
    #1;
    chk("s_idle_req", {31'd0, mem_req}, 32'd0);
    chk("s_idle_ack", {31'd0, data_ack}, 32'd0);

    // Both requesting after reset: instr first, then strict alternation.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    instr_req = 1'b1; instr_addr = 32'h0000_0300;
    data_req = 1'b1; data_be = 4'hF; data_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_ack = 1'b1;
      #1;
      chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'h0000_0300 : 32'h0000_0200);
      chk("rr_instr_ack", {31'd0, instr_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_data_ack", {31'd0, data_ack}, (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("rr_gap_req", {31'd0, mem_req}, 32'd0);
    end
    instr_req = 1'b0; data_req = 1'b0;

    // Error on a load, with fetch waiting ungranted.
    data_addr = 32'h0000_0400; instr_addr = 32'h0000_0500;
    data_req = 1'b1;
    tick();
    instr_req = 1'b1; mem_err = 1'b1;
    #1;
    chk("e_data_err", {31'd0, data_err}, 32'd1);
    chk("e_data_ack", {31'd0, data_ack}, 32'd0);
    chk("e_instr_rsp", {30'd0, instr_ack, instr_err}, 32'd0);
    tick();
    mem_err = 1'b0; data_req = 1'b0;
    tick();
    chk("held_req", {31'd0, mem_req}, 32'd1);
    chk("held_addr", mem_addr, 32'h0000_0500);

    // Reset during a stalled fetch abandons it; fetch is regranted afterwards.
    tick();
    reset = 1'b0;
    tick();
    mem_ack = 1'b1;
    #1;
    chk("rmid_req", {31'd0, mem_req}, 32'd0);
    chk("rmid_ack", {31'd0, instr_ack}, 32'd0);
    mem_ack = 1'b0; reset = 1'b1;
    tick();
    chk("regrant_req", {31'd0, mem_req}, 32'd1);
    chk("regrant_addr", mem_addr, 32'h0000_0500);
    mem_ack = 1'b1;
    #1;
    chk("regrant_ack", {31'd0, instr_ack}, 32'd1);
    tick();
    mem_ack = 1'b0;

    // Requester drops req mid-transfer: response not forwarded.
    tick();
    instr_req = 1'b0; mem_ack = 1'b1;
    #1;
    chk("drop_req", {31'd0, mem_req}, 32'd1);
    chk("drop_ack", {31'd0, instr_ack}, 32'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("drop_idle", {31'd0, mem_req}, 32'd0);

    // Silent memory.
    instr_req = 1'b1; instr_addr = 32'h0000_0600;
    tick();
`ifdef RV32_ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      chk("to_err", {31'd0, instr_err}, (c == 4) ? 32'd1 : 32'd0);
      tick();
    end
    instr_req = 1'b0;
    #1;
    chk("to_idle", {31'd0, mem_req}, 32'd0);
`else
    for (int c = 0; c < 110; c++) begin
      chk("nto_req", {31'd0, mem_req}, 32'd1);
      chk("nto_err", {31'd0, instr_err}, 32'd0);
      tick();
    end
    instr_req = 1'b0;
    reset = 1'b0;
    tick();
    chk("nto_rst", {31'd0, mem_req}, 32'd0);
    reset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
